// File: rtl/fp_acc_seq.sv
// fp_acc_seq: sequential floating-point accumulator for the IIR datapath.
// Folds N packed floats {sign, signed exponent, mantissa} into one running
// sum, one term per cycle, through the combinational `soma` adder, and
// presents the final sum on a valid/ready output port.
// Optional build macro: FP_ACC_ZERO_SKIP_EN (zero operands bypass the adder).
//
// The adder treats every operand as (-1)^s * 1.m * 2^e (hidden one always
// present), so an all-zero word enters the adder as 1.0 * 2^0; this is the
// exponent bump the zero-skip option avoids.

module soma #(
    parameter int EXP = 8,
    parameter int MAN = 23
) (
    input  logic [MAN+EXP:0] a,
    input  logic [MAN+EXP:0] b,
    output logic [MAN+EXP:0] y
);
    localparam int W     = MAN + EXP + 1;
    localparam int POS_W = $clog2(MAN + 1);
    localparam logic [EXP:0]   SHIFT_LIM = (EXP+1)'(MAN + 2);
    localparam logic [EXP-1:0] ONE_E     = {{(EXP-1){1'b0}}, 1'b1};

    logic             a_big_s;
    logic             s_big_s;
    logic             s_small_s;
    logic [EXP-1:0]   e_big_s;
    logic [EXP-1:0]   e_small_s;
    logic [MAN:0]     m_big_s;
    logic [MAN:0]     m_small_s;
    logic [EXP:0]     diff_s;
    logic [MAN:0]     m_sh_s;
    logic [MAN+1:0]   sum_s;
    logic [MAN:0]     dif_s;
    logic [POS_W-1:0] pos_s;
    logic [POS_W-1:0] nsh_s;
    logic [MAN-1:0]   norm_s;

    // Order operands by magnitude and align the smaller one to the larger exponent.
    always_comb begin
        a_big_s = ($signed(a[W-2:MAN]) > $signed(b[W-2:MAN])) ||
                  ((a[W-2:MAN] == b[W-2:MAN]) && (a[MAN-1:0] >= b[MAN-1:0]));
        if (a_big_s) begin
            s_big_s   = a[W-1];
            e_big_s   = a[W-2:MAN];
            m_big_s   = {1'b1, a[MAN-1:0]};
            s_small_s = b[W-1];
            e_small_s = b[W-2:MAN];
            m_small_s = {1'b1, b[MAN-1:0]};
        end else begin
            s_big_s   = b[W-1];
            e_big_s   = b[W-2:MAN];
            m_big_s   = {1'b1, b[MAN-1:0]};
            s_small_s = a[W-1];
            e_small_s = a[W-2:MAN];
            m_small_s = {1'b1, a[MAN-1:0]};
        end
        diff_s = {e_big_s[EXP-1], e_big_s} - {e_small_s[EXP-1], e_small_s};
        if (diff_s >= SHIFT_LIM) begin
            m_sh_s = {(MAN+1){1'b0}};
        end else begin
            m_sh_s = m_small_s >> diff_s;
        end
    end

    // Add or subtract aligned magnitudes, then renormalise (truncating, no rounding).
    always_comb begin
        sum_s = {1'b0, m_big_s} + {1'b0, m_sh_s};
        dif_s = m_big_s - m_sh_s;
        pos_s = {POS_W{1'b0}};
        for (int i = 0; i <= MAN; i++) begin
            if (dif_s[i]) begin
                pos_s = POS_W'(i);
            end else begin
                pos_s = pos_s;
            end
        end
        nsh_s  = POS_W'(MAN) - pos_s;
        norm_s = dif_s[MAN-1:0] << nsh_s;
        if (s_big_s == s_small_s) begin
            if (sum_s[MAN+1]) begin
                y = {s_big_s, e_big_s + ONE_E, sum_s[MAN:1]};
            end else begin
                y = {s_big_s, e_big_s, sum_s[MAN-1:0]};
            end
        end else if (dif_s == {(MAN+1){1'b0}}) begin
            y = {W{1'b0}};
        end else begin
            y = {s_big_s, e_big_s - EXP'(nsh_s), norm_s};
        end
    end
endmodule

module fp_acc_seq #(
    parameter int EXP   = 8,
    parameter int MAN   = 23,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN+EXP:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN+EXP:0]   out_data,
    output logic               busy
);
    localparam int W = MAN + EXP + 1;
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [W-1:0]     WORD_ZERO = {W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [W-1:0]     acc_r, acc_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic             in_ready_r, out_valid_r, busy_r;
    logic [W-1:0]     out_data_r, out_data_s;
    logic [W-1:0]     sum_s;
    logic [W-1:0]     first_val_s;
    logic [W-1:0]     step_val_s;
    logic [LEN_W-1:0] cnt_inc_s;
    logic             xfer_s;

    // True when exponent and mantissa are both zero (sign ignored).
    function automatic logic is_zero(input logic [W-1:0] x);
        return (x[W-2:0] == {(W-1){1'b0}});
    endfunction

    soma #(.EXP(EXP), .MAN(MAN)) u_soma (
        .a (acc_r),
        .b (in_data),
        .y (sum_s)
    );

    // Value loaded by the first term and by each subsequent term.
    always_comb begin
`ifdef FP_ACC_ZERO_SKIP_EN
        first_val_s = is_zero(in_data) ? WORD_ZERO : in_data;
        if (is_zero(in_data)) begin
            step_val_s = acc_r;
        end else if (is_zero(acc_r)) begin
            step_val_s = in_data;
        end else begin
            step_val_s = sum_s;
        end
`else
        first_val_s = in_data;
        step_val_s  = sum_s;
`endif
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        len_s     = len_r;
        xfer_s    = in_valid & in_ready_r;
        cnt_inc_s = cnt_r + CNT_ONE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    len_s = len;
                    cnt_s = CNT_ZERO;
                    if (len == CNT_ZERO) begin
                        acc_s   = WORD_ZERO;
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FIRST;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (xfer_s) begin
                    acc_s = first_val_s;
                    cnt_s = CNT_ONE;
                    if (len_r == CNT_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_FIRST;
                end
            end
            ST_ACC: begin
                if (xfer_s) begin
                    acc_s = step_val_s;
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == len_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s == ST_DONE) begin
            out_data_s = acc_s;
        end else begin
            out_data_s = out_data_r;
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= WORD_ZERO;
            cnt_r       <= CNT_ZERO;
            len_r       <= CNT_ZERO;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= WORD_ZERO;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            len_r       <= len_s;
            in_ready_r  <= (state_s == ST_FIRST) || (state_s == ST_ACC);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
            out_data_r  <= out_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = out_data_r;
endmodule

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
- Sequential floating-point accumulator for the IIR datapath.
- Receives a stream of N packed floats {sign, signed exponent, mantissa} and folds them into one running sum, one term per cycle.
- Instantiates the existing combinational `soma` adder. That adder is fed with the accumulator register and the incoming sample, and its output is registered.
- Sits directly around the adder: drives both adder operands and consumes its result. Presents the final sum downstream with a valid/ready handshake.

Parameters:
- EXP, 8, exponent width (two's-complement signed field).
- MAN, 23, mantissa width.
- LEN_W, 8, width of the term-count input.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a new accumulation (honoured only in IDLE).
- len  in  LEN_W  number of terms N, sampled with start.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  MAN+EXP+1  packed float: [MAN+EXP] sign, [MAN+EXP-1:MAN] exponent, [MAN-1:0] mantissa.
- out_valid  out  1  final sum available.
- out_ready  in  1  downstream consumes the sum.
- out_data  out  MAN+EXP+1  final packed sum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low. While rst=0, every register clears:
  - state=IDLE
  - acc=0 (all-zero word)
  - cnt=0
  - in_ready=0, out_valid=0, busy=0
  - out_data=0
- Reset mid-operation aborts the accumulation. No output is produced for it.
- Handshake: a beat transfers when valid&ready are both high on a rising edge.
- FSM has four states: IDLE, FIRST, ACC, DONE.
- IDLE:
  - in_ready=0.
  - On start=1: latch N=len, cnt=0.
  - If len=0: acc=0, go to DONE.
  - Otherwise go to FIRST.
- FIRST:
  - in_ready=1.
  - On transfer: acc←in_data unchanged (no adder pass), cnt←1.
  - If N=1, go to DONE; otherwise go to ACC.
- ACC:
  - in_ready=1.
  - On transfer: acc←soma(acc, in_data), cnt←cnt+1.
  - When cnt+1==N, go to DONE.
  - No transfer: hold all state.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - Holds stable until out_ready=1.
  - On out_ready=1, go to IDLE the next cycle.
- Throughput: one term per cycle. The adder path is combinational from acc/in_data into the acc register.
- Latency: out_valid rises on the cycle after the Nth transfer.
- start is ignored outside IDLE, including in the DONE cycle that completes the output handshake. A new accumulation needs start in IDLE.
- in_valid while in_ready=0 is ignored; the sample is not consumed.
- cnt is LEN_W bits and never wraps: the maximum term count is 2^LEN_W-1, which terminates exactly at cnt=N.
- Arithmetic: the per-step result is exactly the output of the `soma` adder for (acc, in_data). No extra rounding or normalisation is applied.
- Exponent overflow: unhandled, identical to the adder's behaviour.
- busy = (state != IDLE).

Optional Feature:
- Macro: FP_ACC_ZERO_SKIP_EN.
- Defined:
  - In ACC, a transferred sample whose exponent and mantissa are both zero (sign ignored) counts toward N but leaves acc unchanged.
  - In FIRST, a zero sample loads all-zero.
  - In ACC with acc all-zero (exponent and mantissa both zero), a non-zero sample loads directly instead of passing through the adder.
  - Purpose: avoids the adder's exponent bump on zero operands.
- Undefined: every ACC transfer goes through the adder, whatever its value.

Test Plan:
- Reset: rst=0 asserted asynchronously mid-ACC with N=5 after 2 beats → all outputs 0 immediately. After release: state IDLE, busy=0, no out_valid.
- Single term: start, len=1, in_data=32'h3F800000 → out_valid one cycle after the transfer, out_data=32'h3F800000 exactly.
- Four-term stream: len=4, four consecutive beats → out_valid on the cycle after beat 4. out_data equals a golden model applying the adder's function iteratively, bit-exact.
- Backpressure: len=3, in_valid gapped (1,0,0,1,0,1) → exactly 3 transfers. out_data matches the gap-free run. out_ready held 0 for 5 cycles → out_data stable, out_valid stays 1.
- len=0 and ignored start: start with len=0 → out_valid the next cycle, out_data=0, no in_ready. A start pulse during ACC and during the DONE/out_ready cycle does not restart the block.
- FP_ACC_ZERO_SKIP_EN: len=3, samples {0, 0x3F800000, 0} → out_data=32'h3F800000 with the macro defined. Without the macro, out_data matches the golden model.
